// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// datapath mux selects and the control-word payload.
package ctrl_pkg;

  localparam int unsigned ANCHO_ESTADO = 4;
  localparam int unsigned ANCHO_OP     = 6;

  typedef enum logic [ANCHO_ESTADO-1:0] {
    BUSQUEDA = 4'd0,
    DECOD    = 4'd1,
    DIR_MEM  = 4'd2,
    LEE_MEM  = 4'd3,
    ESC_LW   = 4'd4,
    ESC_MEM  = 4'd5,
    EJEC_R   = 4'd6,
    ESC_R    = 4'd7,
    RAMA     = 4'd8,
    SALTO    = 4'd9,
    EJEC_I   = 4'd10,
    ESC_I    = 4'd11,
    ILEGAL   = 4'd15
  } estado_e;

  localparam logic [ANCHO_OP-1:0] OP_R    = 6'b000000;
  localparam logic [ANCHO_OP-1:0] OP_LW   = 6'b100011;
  localparam logic [ANCHO_OP-1:0] OP_SW   = 6'b101011;
  localparam logic [ANCHO_OP-1:0] OP_BEQ  = 6'b000100;
  localparam logic [ANCHO_OP-1:0] OP_J    = 6'b000010;
  localparam logic [ANCHO_OP-1:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALU_SUMA  = 2'b00;
  localparam logic [1:0] ALU_RESTA = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_B        = 2'b00;
  localparam logic [1:0] ALUB_CUATRO   = 2'b01;
  localparam logic [1:0] ALUB_IMM      = 2'b10;
  localparam logic [1:0] ALUB_IMM_DESP = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SALTO  = 2'b10;

  typedef struct packed {
    logic       escr_pc;
    logic       escr_pc_cond;
    logic       iod;
    logic       leer_mem;
    logic       escr_mem;
    logic       escr_ir;
    logic       mema_reg;
    logic       reg_dest;
    logic       escr_reg;
    logic       fuente_alua;
    logic [1:0] fuente_alub;
    logic [1:0] alu_op;
    logic [1:0] fuente_pc;
  } ctrl_s;

  // Opcode dispatch out of DECOD; anything unrecognised traps.
  function automatic estado_e decod_op(input logic [ANCHO_OP-1:0] op);
    case (op)
      OP_R:         decod_op = EJEC_R;
      OP_LW, OP_SW: decod_op = DIR_MEM;
      OP_BEQ:       decod_op = RAMA;
      OP_J:         decod_op = SALTO;
      OP_ADDI:      decod_op = EJEC_I;
      default:      decod_op = ILEGAL;
    endcase
  endfunction

endpackage

// File: rtl/temporizador_mem.sv
// Memory wait counter: counts cycles spent waiting on mem_listo and flags
// a timeout when the wait would reach ESPERA_MAX.
module temporizador_mem #(
  parameter int unsigned ESPERA_MAX = 16,
  parameter int unsigned ANCHO_CNT  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic activo_i,
  input  logic mem_listo_i,
  output logic timeout_c
);

  logic [ANCHO_CNT-1:0] cnt_q, cnt_d;

  // Counting only while a memory state is stalled; any completion or other state clears.
  always_comb begin
    cnt_d = '0;
    if (activo_i && !mem_listo_i) begin
      cnt_d = cnt_q + ANCHO_CNT'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A ready in the final allowed cycle still completes normally.
  assign timeout_c = activo_i && !mem_listo_i && (cnt_q == ANCHO_CNT'(ESPERA_MAX - 1));

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle main controller: steps the shared datapath through fetch,
// decode, execute, memory and writeback, stalling on the memory handshake.
module control_multiciclo
  import ctrl_pkg::*;
#(
  parameter int unsigned ESPERA_MAX = 16,
  parameter int unsigned ANCHO_CNT  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ANCHO_OP-1:0]     instru,
  input  logic                    cero,
  input  logic                    mem_listo,
  output logic                    EscrPC,
  output logic                    EscrPCCond,
  output logic                    EscrPC_efectivo,
  output logic                    IoD,
  output logic                    LeerMem,
  output logic                    EscrMem,
  output logic                    EscrIR,
  output logic                    MemaReg,
  output logic                    RegDest,
  output logic                    EscrReg,
  output logic                    FuenteALUA,
  output logic [1:0]              FuenteALUB,
  output logic [1:0]              ALUOp,
  output logic [1:0]              FuentePC,
  output logic [ANCHO_ESTADO-1:0] estado,
  output logic                    error
);

  estado_e estado_q, estado_d;
  logic    error_q, error_d;
  logic    espera_c;
  logic    timeout_c;
  ctrl_s   ctrl_c;

  assign espera_c = (estado_q == BUSQUEDA) || (estado_q == LEE_MEM) || (estado_q == ESC_MEM);

  temporizador_mem #(
    .ESPERA_MAX (ESPERA_MAX),
    .ANCHO_CNT  (ANCHO_CNT)
  ) u_temporizador (
    .clk         (clk),
    .rst         (rst),
    .activo_i    (espera_c),
    .mem_listo_i (mem_listo),
    .timeout_c   (timeout_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= BUSQUEDA;
      error_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    ctrl_c   = '0;
    case (estado_q)
      BUSQUEDA: begin
        ctrl_c.leer_mem    = 1'b1;
        ctrl_c.fuente_alub = ALUB_CUATRO;
        ctrl_c.alu_op      = ALU_SUMA;
        ctrl_c.fuente_pc   = PC_ALU;
        if (mem_listo) begin
          ctrl_c.escr_ir = 1'b1;
          ctrl_c.escr_pc = 1'b1;
          estado_d       = DECOD;
        end else if (timeout_c) begin
          estado_d = ILEGAL;
        end
      end
      DECOD: begin
        ctrl_c.fuente_alub = ALUB_IMM_DESP;
        ctrl_c.alu_op      = ALU_SUMA;
        estado_d           = decod_op(instru);
      end
      DIR_MEM: begin
        ctrl_c.fuente_alua = 1'b1;
        ctrl_c.fuente_alub = ALUB_IMM;
        ctrl_c.alu_op      = ALU_SUMA;
        estado_d           = (instru == OP_LW) ? LEE_MEM : ESC_MEM;
      end
      LEE_MEM: begin
        ctrl_c.leer_mem = 1'b1;
        ctrl_c.iod      = 1'b1;
        if (mem_listo) begin
          estado_d = ESC_LW;
        end else if (timeout_c) begin
          estado_d = ILEGAL;
        end
      end
      ESC_LW: begin
        ctrl_c.escr_reg = 1'b1;
        ctrl_c.mema_reg = 1'b1;
        estado_d        = BUSQUEDA;
      end
      ESC_MEM: begin
        ctrl_c.escr_mem = 1'b1;
        ctrl_c.iod      = 1'b1;
        if (mem_listo) begin
          estado_d = BUSQUEDA;
        end else if (timeout_c) begin
          estado_d = ILEGAL;
        end
      end
      EJEC_R: begin
        ctrl_c.fuente_alua = 1'b1;
        ctrl_c.fuente_alub = ALUB_B;
        ctrl_c.alu_op      = ALU_FUNCT;
        estado_d           = ESC_R;
      end
      ESC_R: begin
        ctrl_c.escr_reg = 1'b1;
        ctrl_c.reg_dest = 1'b1;
        estado_d        = BUSQUEDA;
      end
      RAMA: begin
        ctrl_c.fuente_alua  = 1'b1;
        ctrl_c.fuente_alub  = ALUB_B;
        ctrl_c.alu_op       = ALU_RESTA;
        ctrl_c.escr_pc_cond = 1'b1;
        ctrl_c.fuente_pc    = PC_ALUOUT;
        estado_d            = BUSQUEDA;
      end
      SALTO: begin
        ctrl_c.escr_pc   = 1'b1;
        ctrl_c.fuente_pc = PC_SALTO;
        estado_d         = BUSQUEDA;
      end
      EJEC_I: begin
        ctrl_c.fuente_alua = 1'b1;
        ctrl_c.fuente_alub = ALUB_IMM;
        ctrl_c.alu_op      = ALU_SUMA;
        estado_d           = ESC_I;
      end
      ESC_I: begin
        ctrl_c.escr_reg = 1'b1;
        estado_d        = BUSQUEDA;
      end
      ILEGAL: begin
        estado_d = ILEGAL;
      end
      default: begin
        estado_d = ILEGAL;
      end
    endcase
  end

  // Error is sticky: it rises together with the trap state and only rst clears it.
  assign error_d = error_q || (estado_d == ILEGAL);

  assign EscrPC          = ctrl_c.escr_pc;
  assign EscrPCCond      = ctrl_c.escr_pc_cond;
  assign EscrPC_efectivo = ctrl_c.escr_pc || (ctrl_c.escr_pc_cond && cero);
  assign IoD             = ctrl_c.iod;
  assign LeerMem         = ctrl_c.leer_mem;
  assign EscrMem         = ctrl_c.escr_mem;
  assign EscrIR          = ctrl_c.escr_ir;
  assign MemaReg         = ctrl_c.mema_reg;
  assign RegDest         = ctrl_c.reg_dest;
  assign EscrReg         = ctrl_c.escr_reg;
  assign FuenteALUA      = ctrl_c.fuente_alua;
  assign FuenteALUB      = ctrl_c.fuente_alub;
  assign ALUOp           = ctrl_c.alu_op;
  assign FuentePC        = ctrl_c.fuente_pc;
  assign estado          = estado_q;
  assign error           = error_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Randomised bench for control_multiciclo: expected state traces are built
// from instruction-level rules and checked cycle by cycle.
module tb_control_multiciclo;

  localparam int unsigned TB_ESPERA = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] instru = '0;
  logic       cero = 1'b0;
  logic       mem_listo = 1'b0;
  logic       EscrPC, EscrPCCond, EscrPC_efectivo, IoD, LeerMem, EscrMem, EscrIR;
  logic       MemaReg, RegDest, EscrReg, FuenteALUA, error;
  logic [1:0] FuenteALUB, ALUOp, FuentePC;
  logic [3:0] estado;
  logic [17:0] act_v;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int st;
    bit mem;
    bit listo;
  } paso_t;

  paso_t traza[$];

  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_J = 6'b000010, T_ADDI = 6'b001000;

  control_multiciclo #(.ESPERA_MAX(TB_ESPERA), .ANCHO_CNT(8)) dut (
    .clk(clk), .rst(rst), .instru(instru), .cero(cero), .mem_listo(mem_listo),
    .EscrPC(EscrPC), .EscrPCCond(EscrPCCond), .EscrPC_efectivo(EscrPC_efectivo),
    .IoD(IoD), .LeerMem(LeerMem), .EscrMem(EscrMem), .EscrIR(EscrIR),
    .MemaReg(MemaReg), .RegDest(RegDest), .EscrReg(EscrReg),
    .FuenteALUA(FuenteALUA), .FuenteALUB(FuenteALUB), .ALUOp(ALUOp),
    .FuentePC(FuentePC), .estado(estado), .error(error)
  );

  always #5 clk = ~clk;

  assign act_v = {EscrPC, EscrPCCond, EscrPC_efectivo, IoD, LeerMem, EscrMem, EscrIR,
                  MemaReg, RegDest, EscrReg, FuenteALUA, FuenteALUB, ALUOp, FuentePC, error};

  // Control word each state must present, read straight from the state table.
  function automatic logic [17:0] esperado(input int st, input logic listo, input logic c);
    logic epc, pcc, iod, lm, em, eir, mr, rd, er, aa, err;
    logic [1:0] ab, op, fp;
    {epc, pcc, iod, lm, em, eir, mr, rd, er, aa, err} = '0;
    ab = 2'b00; op = 2'b00; fp = 2'b00;
    case (st)
      0:  begin lm = 1; ab = 2'b01; epc = listo; eir = listo; end
      1:  ab = 2'b11;
      2:  begin aa = 1; ab = 2'b10; end
      3:  begin lm = 1; iod = 1; end
      4:  begin er = 1; mr = 1; end
      5:  begin em = 1; iod = 1; end
      6:  begin aa = 1; op = 2'b10; end
      7:  begin er = 1; rd = 1; end
      8:  begin aa = 1; op = 2'b01; pcc = 1; fp = 2'b01; end
      9:  begin epc = 1; fp = 2'b10; end
      10: begin aa = 1; ab = 2'b10; end
      11: er = 1;
      15: err = 1;
      default: ;
    endcase
    return {epc, pcc, epc | (pcc & c), iod, lm, em, eir, mr, rd, er, aa, ab, op, fp, err};
  endfunction

  function automatic bit add_wait(input int st, input int w);
    paso_t p;
    p.st = st; p.mem = 1'b1; p.listo = 1'b0;
    if (w >= int'(TB_ESPERA)) begin
      for (int i = 0; i < int'(TB_ESPERA); i++) traza.push_back(p);
      p.st = 15; p.mem = 1'b0;
      traza.push_back(p);
      return 1'b0;
    end
    for (int i = 0; i < w; i++) traza.push_back(p);
    p.listo = 1'b1;
    traza.push_back(p);
    return 1'b1;
  endfunction

  function automatic void empuja(input int st);
    paso_t p;
    p.st = st; p.mem = 1'b0; p.listo = 1'b0;
    traza.push_back(p);
  endfunction

  // Expected state sequence of one instruction: fetch waits fw, data waits mw.
  function automatic void construir(input logic [5:0] op, input int fw, input int mw);
    traza.delete();
    if (!add_wait(0, fw)) return;
    empuja(1);
    case (op)
      T_R:    begin empuja(6); empuja(7); end
      T_LW:   begin empuja(2); if (add_wait(3, mw)) empuja(4); end
      T_SW:   begin empuja(2); void'(add_wait(5, mw)); end
      T_BEQ:  empuja(8);
      T_J:    empuja(9);
      T_ADDI: begin empuja(10); empuja(11); end
      default: empuja(15);
    endcase
  endfunction

  task automatic run_trace(input string nombre, input logic [5:0] op, input bit ruido,
                           input logic cero_rama, input int max_len);
    logic [17:0] exp_v;
    for (int i = 0; i < traza.size() && i < max_len; i++) begin
      instru = op;
      if (traza[i].mem) mem_listo = traza[i].listo;
      else mem_listo = ruido ? 1'($urandom) : 1'b1;
      cero = (traza[i].st == 8) ? cero_rama : 1'($urandom);
      @(negedge clk);
      exp_v = esperado(traza[i].st, mem_listo, cero);
      n_checks++;
      if (estado !== 4'(traza[i].st)) begin
        n_errors++;
        $display("FAIL %s paso %0d estado got %0d exp %0d", nombre, i, estado, traza[i].st);
      end
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL %s paso %0d ctrl got %b exp %b", nombre, i, act_v, exp_v);
      end
      n_checks++;
      if (LeerMem === 1'b1 && EscrMem === 1'b1) begin
        n_errors++;
        $display("FAIL %s paso %0d LeerMem and EscrMem both 1", nombre, i);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulso_reset(input string nombre);
    rst = 1'b1;
    mem_listo = 1'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (estado !== 4'd0 || error !== 1'b0) begin
      n_errors++;
      $display("FAIL %s estado got %0d error got %b exp 0/0", nombre, estado, error);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      instru = 6'($urandom);
      mem_listo = 1'($urandom);
      @(posedge clk);
      #1;
      n_checks++;
      if (estado !== 4'd0 || error !== 1'b0) begin
        n_errors++;
        $display("FAIL reset ciclo %0d estado got %0d error got %b exp 0/0", i, estado, error);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_r_type();
    construir(T_R, 0, 0);
    run_trace("r_type", T_R, 1'b0, 1'b0, 100);
  endtask

  task automatic test_lw_wait();
    construir(T_LW, 0, 3);
    run_trace("lw_wait", T_LW, 1'b1, 1'b0, 100);
  endtask

  task automatic test_beq();
    construir(T_BEQ, 0, 0);
    run_trace("beq_tomado", T_BEQ, 1'b1, 1'b1, 100);
    construir(T_BEQ, 1, 0);
    run_trace("beq_no_tomado", T_BEQ, 1'b1, 1'b0, 100);
  endtask

  task automatic test_ilegal();
    construir(6'b111111, 0, 0);
    run_trace("ilegal", 6'b111111, 1'b1, 1'b0, 100);
    for (int i = 0; i < 20; i++) begin
      mem_listo = 1'(i & 1);
      instru = 6'($urandom);
      @(negedge clk);
      n_checks++;
      if (estado !== 4'd15 || error !== 1'b1) begin
        n_errors++;
        $display("FAIL ilegal_hold ciclo %0d estado got %0d error got %b exp 15/1", i, estado, error);
      end
      @(posedge clk);
      #1;
    end
    pulso_reset("ilegal_reset");
  endtask

  task automatic test_timeout();
    construir(T_SW, 0, 4);
    run_trace("sw_timeout", T_SW, 1'b1, 1'b0, 100);
    pulso_reset("sw_timeout_reset");
    construir(T_SW, 0, 3);
    run_trace("sw_listo_limite", T_SW, 1'b1, 1'b0, 100);
    construir(T_R, 0, 0);
    run_trace("tras_limite", T_R, 1'b1, 1'b0, 100);
    construir(T_J, 4, 0);
    run_trace("fetch_timeout", T_J, 1'b1, 1'b0, 100);
    pulso_reset("fetch_timeout_reset");
  endtask

  task automatic test_reset_mid();
    construir(T_LW, 0, 3);
    run_trace("lw_parcial", T_LW, 1'b1, 1'b0, 5);
    rst = 1'b1;
    mem_listo = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    construir(T_ADDI, 3, 0);
    run_trace("tras_reset_mid", T_ADDI, 1'b1, 1'b0, 100);
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    logic [5:0] op;
    ops[0] = T_R; ops[1] = T_LW; ops[2] = T_SW; ops[3] = T_BEQ; ops[4] = T_J; ops[5] = T_ADDI;
    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 5)];
      construir(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run_trace("aleatorio", op, 1'b1, 1'($urandom), 100);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_beq();
    test_ilegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
- Multicycle main controller. Sequences the shared datapath (single memory, ALU, register file, PC/IR registers) through fetch, decode, execute, memory and writeback steps, one step per cycle.
- Stalls on a memory ready handshake.
- Flags illegal opcodes and memory timeouts as a sticky error.
- Sits between the IR opcode field and the datapath mux/write-enable controls.

Parameters:
- ESPERA_MAX, 16, maximum cycles a memory access may wait for mem_listo before error (valid range 1..255).
- ANCHO_CNT, 8, width of the wait counter; must hold ESPERA_MAX.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- instru  in  6  opcode field of IR (bits 31:26).
- cero  in  1  ALU zero flag, valid during RAMA.
- mem_listo  in  1  memory completes the current access this cycle.
- EscrPC  out  1  unconditional PC write.
- EscrPCCond  out  1  PC write qualified by cero (controller ANDs internally into EscrPC_efectivo).
- EscrPC_efectivo  out  1  EscrPC | (EscrPCCond & cero).
- IoD  out  1  memory address source: 0 = PC, 1 = ALUOut.
- LeerMem  out  1  memory read request.
- EscrMem  out  1  memory write request.
- EscrIR  out  1  IR load.
- MemaReg  out  1  writeback source: 1 = MDR, 0 = ALUOut.
- RegDest  out  1  destination: 1 = rd, 0 = rt.
- EscrReg  out  1  register file write.
- FuenteALUA  out  1  0 = PC, 1 = reg A.
- FuenteALUB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- FuentePC  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- estado  out  4  current state code, for debug.
- error  out  1  sticky fault flag.

Behaviour:
- State register updates on posedge clk. All outputs are a combinational decode of state, except where qualified by mem_listo or cero below.
- Reset: rst = 1 at a clock edge forces state to BUSQUEDA, wait counter to 0 and error to 0. This applies mid-access too; the pending memory access is abandoned.
- Outputs not listed in a state are 0.
- State codes:
  - BUSQUEDA = 0: LeerMem = 1, IoD = 0, FuenteALUA = 0, FuenteALUB = 01, ALUOp = 00, FuentePC = 00. EscrIR and EscrPC are asserted only in the cycle where mem_listo = 1, which is also when the state advances to DECOD. Otherwise the state holds.
  - DECOD = 1: FuenteALUA = 0, FuenteALUB = 11, ALUOp = 00 (branch target precompute). Next state by instru:
    - 000000 -> EJEC_R
    - 100011 or 101011 -> DIR_MEM
    - 000100 -> RAMA
    - 000010 -> SALTO
    - 001000 -> EJEC_I
    - any other -> ILEGAL
  - DIR_MEM = 2: FuenteALUA = 1, FuenteALUB = 10, ALUOp = 00. Next is LEE_MEM if instru = 100011, else ESC_MEM.
  - LEE_MEM = 3: LeerMem = 1, IoD = 1. Waits for mem_listo, then goes to ESC_LW.
  - ESC_LW = 4: EscrReg = 1, MemaReg = 1, RegDest = 0. Next is BUSQUEDA.
  - ESC_MEM = 5: EscrMem = 1, IoD = 1. Waits for mem_listo, then goes to BUSQUEDA.
  - EJEC_R = 6: FuenteALUA = 1, FuenteALUB = 00, ALUOp = 10. Next is ESC_R.
  - ESC_R = 7: EscrReg = 1, RegDest = 1, MemaReg = 0. Next is BUSQUEDA.
  - RAMA = 8: FuenteALUA = 1, FuenteALUB = 00, ALUOp = 01, EscrPCCond = 1, FuentePC = 01. Next is BUSQUEDA.
  - SALTO = 9: EscrPC = 1, FuentePC = 10. Next is BUSQUEDA.
  - EJEC_I = 10: FuenteALUA = 1, FuenteALUB = 10, ALUOp = 00. Next is ESC_I.
  - ESC_I = 11: EscrReg = 1, RegDest = 0, MemaReg = 0. Next is BUSQUEDA.
  - ILEGAL = 15: error = 1, no write enables, holds until rst.
- Wait counter:
  - Increments each cycle in BUSQUEDA, LEE_MEM or ESC_MEM while mem_listo = 0.
  - Clears on mem_listo = 1 and on entry to any other state.
  - If the counter reaches ESPERA_MAX with mem_listo still 0, the next state is ILEGAL and error is set.
  - mem_listo = 1 in the same cycle the counter hits ESPERA_MAX: the access completes normally and there is no error.
- mem_listo asserted in a non-memory state is ignored.
- Latency with zero-wait memory: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles. Each memory wait cycle adds 1.
- instru is sampled only in DECOD and DIR_MEM. IR must stay stable after EscrIR.
- Never assert EscrMem and LeerMem together. Never assert EscrReg in a memory-wait state.

Decomposition:
- Package ctrl_pkg holds:
  - state codes (4-bit localparams)
  - opcode constants OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp and FuenteALUB/FuentePC encodings
- One sub-module is natural: temporizador_mem (wait counter plus timeout compare), parameterised by ESPERA_MAX and ANCHO_CNT.

Test Plan:
- rst = 1 for 2 cycles, then instru = 000000, mem_listo = 1 always -> states 0, 1, 6, 7, 0. EscrReg = 1 and RegDest = 1 only in state 7. EscrIR = 1 only in cycle 1.
- lw (100011), mem_listo low for 3 cycles in LEE_MEM -> states 0, 1, 2, 3, 3, 3, 3, 4, 0. LeerMem = 1 and IoD = 1 throughout state 3; MemaReg = 1 in state 4.
- beq (000100) twice, with cero = 1 then cero = 0 in RAMA -> EscrPC_efectivo = 1 with FuentePC = 01 the first time, EscrPC_efectivo = 0 the second; both return to state 0.
- instru = 111111 -> state 15 with error = 1. Stays there for 20 cycles despite mem_listo toggling; rst returns state to 0 and error to 0.
- ESPERA_MAX = 4, sw with mem_listo held 0 -> after 4 wait cycles in state 5, state becomes 15 and error = 1. Repeat with mem_listo = 1 on the 4th wait cycle -> returns to state 0 with error = 0.
- rst asserted during LEE_MEM wait -> next cycle state = 0, LeerMem = 1, IoD = 0, wait counter = 0.
